// File: rtl/mem_l2_arb2_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_l2_arb2_if: one OPM/OK request port (addresses, data, opcode, OK)
// Rev 1.0
// ------------------------------------------------------------------
interface mem_l2_arb2_if #(
   parameter int ADDR_W = 48,
   parameter int TILE_W = 128,
   parameter int OPM_W  = 16
) ();
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_b;
   logic [TILE_W-1:0] wdata;
   logic [TILE_W-1:0] rdata;
   logic [OPM_W-1:0]  opm;
   logic [1:0]        ok;

   modport master (output addr, addr_b, wdata, opm, input rdata, ok);
   modport slave  (input addr, addr_b, wdata, opm, output rdata, ok);
endinterface
`default_nettype wire

// File: rtl/mem_l2_arb2.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_l2_arb2: round-robin 2:1 arbiter onto the registered L2 OPM/OK port
// Rev 1.0
// ------------------------------------------------------------------
module mem_l2_arb2 #(
   parameter int ADDR_W   = 48,
   parameter int TILE_W   = 128,
   parameter int OPM_W    = 16,
   parameter int WDOG_MAX = 65535
) (
   input  wire logic      clk_i,
   input  wire logic      rst_i,
   mem_l2_arb2_if.slave   req_a_if,
   mem_l2_arb2_if.slave   req_b_if,
   mem_l2_arb2_if.master  mem_if,
   output logic [1:0]     arb_grant_o,
   output logic           arb_stall_o
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GNT_A = 2'd1;
   localparam logic [1:0] S_GNT_B = 2'd2;
   localparam logic [1:0] S_TDOWN = 2'd3;

   localparam logic [1:0] OK_READY = 2'b00;
   localparam logic [1:0] OK_OK    = 2'b01;
   localparam logic [1:0] OK_HOLD  = 2'b10;
   localparam logic [1:0] OK_FAULT = 2'b11;

   localparam int             WD_W  = $clog2(WDOG_MAX + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_MAX);

   logic [1:0]        state_q, state_d;
   logic              last_b_q, last_b_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0] mem_addr_b_q, mem_addr_b_d;
   logic [TILE_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [OPM_W-1:0]  mem_opm_q, mem_opm_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              stall_q, stall_d;

   logic a_act, b_act, ok_done;
   logic load_en, load_sel_b, opm_clear;

   assign a_act   = (req_a_if.opm[4:0] != 5'd0);
   assign b_act   = (req_b_if.opm[4:0] != 5'd0);
   assign ok_done = (mem_if.ok == OK_OK) || (mem_if.ok == OK_FAULT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         last_b_q     <= 1'b1;
         done_q       <= 1'b0;
         mem_addr_q   <= '0;
         mem_addr_b_q <= '0;
         mem_wdata_q  <= '0;
         mem_opm_q    <= '0;
         wdog_q       <= '0;
         stall_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_b_q     <= last_b_d;
         done_q       <= done_d;
         mem_addr_q   <= mem_addr_d;
         mem_addr_b_q <= mem_addr_b_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_opm_q    <= mem_opm_d;
         wdog_q       <= wdog_d;
         stall_q      <= stall_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_b_d   = last_b_q;
      done_d     = done_q;
      load_en    = 1'b0;
      load_sel_b = 1'b0;
      opm_clear  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // On a tie the requester that did not go last wins
            if (a_act && (!b_act || last_b_q)) begin
               state_d = S_GNT_A;
               load_en = 1'b1;
            end else if (b_act) begin
               state_d    = S_GNT_B;
               load_en    = 1'b1;
               load_sel_b = 1'b1;
            end
         end
         S_GNT_A, S_GNT_B: begin
            load_en    = 1'b1;
            load_sel_b = (state_q == S_GNT_B);
            done_d     = done_q | ok_done;
            if (done_q && !(load_sel_b ? b_act : a_act)) begin
               opm_clear = 1'b1;
               last_b_d  = load_sel_b;
               done_d    = 1'b0;
               state_d   = S_TDOWN;
            end
         end
         S_TDOWN: begin
            opm_clear = 1'b1;
            if (mem_if.ok == OK_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      mem_addr_d   = mem_addr_q;
      mem_addr_b_d = mem_addr_b_q;
      mem_wdata_d  = mem_wdata_q;
      mem_opm_d    = mem_opm_q;
      if (load_en) begin
         mem_addr_d   = load_sel_b ? req_b_if.addr   : req_a_if.addr;
         mem_addr_b_d = load_sel_b ? req_b_if.addr_b : req_a_if.addr_b;
         mem_wdata_d  = load_sel_b ? req_b_if.wdata  : req_a_if.wdata;
         mem_opm_d    = load_sel_b ? req_b_if.opm    : req_a_if.opm;
      end
      if (opm_clear) mem_opm_d = '0;

      // Watchdog only observes; a stuck L2 is flagged, never aborted
      wdog_d = wdog_q;
      if (state_d == S_IDLE) wdog_d = '0;
      else if ((state_q != S_IDLE) && (wdog_q != WD_MAX)) wdog_d = wdog_q + 1'b1;
      stall_d = stall_q | (wdog_d == WD_MAX);
   end

   always_comb begin
      arb_grant_o    = {state_q == S_GNT_B, state_q == S_GNT_A};
      req_a_if.rdata = '0;
      req_a_if.ok    = a_act ? OK_HOLD : OK_READY;
      req_b_if.rdata = '0;
      req_b_if.ok    = b_act ? OK_HOLD : OK_READY;
      if (state_q == S_GNT_A) begin
         req_a_if.rdata = mem_if.rdata;
         req_a_if.ok    = mem_if.ok;
      end
      if (state_q == S_GNT_B) begin
         req_b_if.rdata = mem_if.rdata;
         req_b_if.ok    = mem_if.ok;
      end
   end

   assign mem_if.addr   = mem_addr_q;
   assign mem_if.addr_b = mem_addr_b_q;
   assign mem_if.wdata  = mem_wdata_q;
   assign mem_if.opm    = mem_opm_q;
   assign arb_stall_o   = stall_q;
endmodule
`default_nettype wire
